spi_frame_trig: RTL and testbench
=================================

// Module: spi_frame_trig
// PURPOSE
//  Passive SPI sniffer/trigger stage, directly downstream of the SPI simulator on the housekeeping bus.
//  Samples CS/SCLK/MOSI/MISO from the simulator output or the N expansion connector.
//  Shifts each frame into 32-bit MOSI/MISO registers and compares against masked patterns.
//  Emits trigger pulses for the scope and LEDs. All configuration goes through the system bus at offsets 0x60-0x7C.
// PARAMETERS
//  SYNC_STG  2   input synchroniser depth, >=2
//  TRG_LEN   8   trg_o / mosi_trg_o pulse width in clk_i cycles, >=1
// PORTS
//  clk_i        in   1   system clock
//  rstn_i       in   1   asynchronous reset, active low
//  spi_cs_i     in   1   chip select, active low, asynchronous to clk_i
//  spi_sclk_i   in   1   SPI clock, asynchronous; data sampled on rising edge (mode 0)
//  spi_mosi_i   in   1   master-out data
//  spi_miso_i   in   1   slave-out data
//  sys_addr     in   32  bus address; [19:0] decoded
//  sys_wdata    in   32  bus write data
//  sys_wen      in   1   bus write strobe, 1 cycle
//  sys_ren      in   1   bus read strobe, 1 cycle
//  sys_rdata    out  32  read data, valid with sys_ack
//  sys_ack      out  1   acknowledge, asserted only for own addresses
//  trg_o        out  1   frame trigger pulse
//  mosi_trg_o   out  1   MOSI-match pulse
//  busy_o       out  1   high while a frame is being captured
// BEHAVIOUR
//  Reset: every output, every register, FSM=IDLE and all counters go to 0; masks go to 0 (all bits don't-care).
//  Register map (R/W unless stated):
//    0x60 mosi_mask   0x64 mosi_pat   0x68 miso_flag[0]   0x6C miso_mask   0x70 miso_pat
//    0x74 nbits[5:0]: 0 or >32 is treated as 32
//    0x78 ctrl: [0]=enable
//    0x7C status (RO): [15:0]=trigger count (wraps 0xFFFF->0), [31:16]=abort count (wraps)
//  Writes to 0x7C clear both counters.
//  Bus timing: sys_ack and sys_rdata register one cycle after sys_wen/sys_ren when addr is in 0x60..0x7C.
//  sys_ack stays 0 for other addresses; there is no error output.
//  Inputs: each input passes a SYNC_STG flop chain. SCLK rise = sync'd sclk 0->1 (prev vs cur).
//  CS fall and CS rise are detected the same way. Pin-to-edge latency is SYNC_STG+1 cycles.
//  Shadowing: on CS fall, all pattern/mask/flag/nbits registers copy into shadow regs.
//  Bus writes during a frame therefore affect only the next frame.
//  FSM:
//    IDLE : CS fall && enable -> SHIFT (clear shift regs, bit_cnt=0). A CS fall while disabled is ignored.
//    SHIFT: each SCLK rise shifts MSB-first, sr <= {sr[30:0],bit}, bit_cnt++.
//           bit_cnt==nbits -> EVAL.
//           CS rise before that -> IDLE with abort_cnt++ and no compare.
//    EVAL : one cycle, compares only the low nbits bits.
//           mosi_hit = ((mosi_sr^mosi_pat)&mosi_mask)==0; miso_hit is the same form on MISO.
//           Fire = mosi_hit && (!miso_flag || miso_hit). -> HOLD.
//    HOLD : ignores further SCLK edges; CS rise -> IDLE.
//  Simultaneous SCLK rise and CS rise: the edge is shifted first and then the abort test runs.
//  So a final bit arriving together with CS rise still completes the frame.
//  Outputs:
//    busy_o = (state!=IDLE).
//    mosi_trg_o rises the cycle after EVAL when mosi_hit=1; trg_o rises the cycle after EVAL when Fire=1.
//    Both pulses are exactly TRG_LEN cycles. A re-fire during a pulse restarts the width counter.
//    trig_cnt increments once per Fire.
//  Clearing enable mid-frame: the current frame completes; only the next CS fall is blocked.
//  Asynchronous reset mid-frame: all state is dropped immediately and pulses stop.
// TESTING
//  T1 nbits=8, mosi_pat=0xA5, mosi_mask=0xFF, flag=0, send 0xA5 -> trg_o and mosi_trg_o each high 8 cycles; 0x7C reads 0x00000001.
//  T2 same config, send 0xA4 -> no pulses; mask=0xFE then send 0xA4 -> trg_o fires.
//  T3 flag=1, miso_pat=0x3C, miso_mask=0xFF, MOSI 0xA5 with MISO 0x3D -> mosi_trg_o only, no trg_o.
//     Same frame with MISO 0x3C -> both pulses fire.
//  T4 CS rises after 5 of 8 bits -> no pulses; 0x7C[31:16]=1; busy_o back to 0.
//  T5 write mosi_pat=0x00 mid-frame while sending 0xA5 (pattern 0xA5) -> this frame fires and the next 0xA5 frame does not.
//     Also nbits=0, 32-bit frame 0xDEADBEEF matched -> fires.
//  T6 assert rstn_i mid-frame and during a pulse -> outputs 0 in the same cycle; the next full frame fires normally.
//     Bus read at 0x0C -> sys_ack stays 0.

Source files
------------

// File: rtl/spi_frame_trig.sv
// Passive SPI frame sniffer: captures MOSI/MISO per CS frame, compares masked patterns, emits trigger pulses.
// Bus reads/writes ack one cycle after the strobe; there is no backpressure, SPI edges are sampled every clk_i.
module spi_frame_trig #(
  parameter int SYNC_STG = 2,
  parameter int TRG_LEN  = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        spi_cs_i,
  input  logic        spi_sclk_i,
  input  logic        spi_mosi_i,
  input  logic        spi_miso_i,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_ack,
  output logic        trg_o,
  output logic        mosi_trg_o,
  output logic        busy_o
);
  localparam int PW = $clog2(TRG_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, EVAL, HOLD} state_t;

  typedef struct packed {
    logic [31:0] mosi_mask;
    logic [31:0] mosi_pat;
    logic        miso_flag;
    logic [31:0] miso_mask;
    logic [31:0] miso_pat;
    logic [5:0]  nbits;
  } cfg_t;

  logic [3:0]  sync_q [SYNC_STG];
  logic [3:0]  sync_d [SYNC_STG];
  logic [1:0]  prev_q, prev_d;
  state_t      state_q, state_d;
  cfg_t        cfg_q, cfg_d, shd_q, shd_d;
  logic        en_q, en_d;
  logic [31:0] mosi_sr_q, mosi_sr_d, miso_sr_q, miso_sr_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] trig_cnt_q, trig_cnt_d, abort_cnt_q, abort_cnt_d;
  logic [PW-1:0] mpw_q, mpw_d, tpw_q, tpw_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  logic        cs_cur, sclk_cur, mosi_cur, miso_cur;
  logic        cs_fall, cs_rise, sclk_rise;
  logic        bus_hit, wr, rd;
  logic [2:0]  idx;
  logic [31:0] len_mask, rd_val;
  logic        mosi_hit, miso_hit, fire;
  logic [11:0] unused_addr;

  assign {cs_cur, sclk_cur, mosi_cur, miso_cur} = sync_q[SYNC_STG-1];
  assign cs_fall   =  prev_q[1] & ~cs_cur;
  assign cs_rise   = ~prev_q[1] &  cs_cur;
  assign sclk_rise = ~prev_q[0] &  sclk_cur;

  assign bus_hit = (sys_addr[19:5] == 15'h3) && (sys_addr[1:0] == 2'b00);
  assign wr      = sys_wen & bus_hit;
  assign rd      = sys_ren & bus_hit;
  assign idx     = sys_addr[4:2];
  assign unused_addr = sys_addr[31:20];

  // Only the low nbits of each shift register belong to the frame.
  assign len_mask = (shd_q.nbits == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << shd_q.nbits) - 32'd1);
  assign mosi_hit = (((mosi_sr_q ^ shd_q.mosi_pat) & shd_q.mosi_mask & len_mask) == 32'd0);
  assign miso_hit = (((miso_sr_q ^ shd_q.miso_pat) & shd_q.miso_mask & len_mask) == 32'd0);
  assign fire     = mosi_hit && (!shd_q.miso_flag || miso_hit);

  assign busy_o     = (state_q != IDLE);
  assign trg_o      = (tpw_q != '0);
  assign mosi_trg_o = (mpw_q != '0);
  assign sys_ack    = ack_q;
  assign sys_rdata  = rdata_q;

  always_comb begin
    sync_d[0] = {spi_cs_i, spi_sclk_i, spi_mosi_i, spi_miso_i};
    for (int i = 1; i < SYNC_STG; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      3'd0: rd_val = cfg_q.mosi_mask;
      3'd1: rd_val = cfg_q.mosi_pat;
      3'd2: rd_val = {31'd0, cfg_q.miso_flag};
      3'd3: rd_val = cfg_q.miso_mask;
      3'd4: rd_val = cfg_q.miso_pat;
      3'd5: rd_val = {26'd0, cfg_q.nbits};
      3'd6: rd_val = {31'd0, en_q};
      default: rd_val = {abort_cnt_q, trig_cnt_q};
    endcase
  end

  always_comb begin
    prev_d      = {cs_cur, sclk_cur};
    state_d     = state_q;
    cfg_d       = cfg_q;
    shd_d       = shd_q;
    en_d        = en_q;
    mosi_sr_d   = mosi_sr_q;
    miso_sr_d   = miso_sr_q;
    bit_cnt_d   = bit_cnt_q;
    trig_cnt_d  = trig_cnt_q;
    abort_cnt_d = abort_cnt_q;
    mpw_d       = (mpw_q != '0) ? mpw_q - PW'(1) : mpw_q;
    tpw_d       = (tpw_q != '0) ? tpw_q - PW'(1) : tpw_q;
    ack_d       = (sys_wen | sys_ren) & bus_hit;
    rdata_d     = rd ? rd_val : 32'd0;

    // Snapshot config at frame start so mid-frame writes only affect the next frame.
    if (state_q == IDLE && cs_fall) begin
      shd_d = cfg_q;
      if (cfg_q.nbits == 6'd0 || cfg_q.nbits > 6'd32) shd_d.nbits = 6'd32;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall && en_q) begin
          state_d   = SHIFT;
          mosi_sr_d = '0;
          miso_sr_d = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          mosi_sr_d = {mosi_sr_q[30:0], mosi_cur};
          miso_sr_d = {miso_sr_q[30:0], miso_cur};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
        if (sclk_rise && (bit_cnt_q + 6'd1 == shd_q.nbits)) begin
          state_d = EVAL;
        end else if (cs_rise) begin
          state_d     = IDLE;
          abort_cnt_d = abort_cnt_q + 16'd1;
        end
      end
      EVAL: begin
        if (mosi_hit) mpw_d = PW'(TRG_LEN);
        if (fire) begin
          tpw_d      = PW'(TRG_LEN);
          trig_cnt_d = trig_cnt_q + 16'd1;
        end
        state_d = HOLD;
      end
      default: begin
        // Level test also covers a CS rise that coincided with the last bit.
        if (cs_cur) state_d = IDLE;
      end
    endcase

    if (wr) begin
      case (idx)
        3'd0: cfg_d.mosi_mask = sys_wdata;
        3'd1: cfg_d.mosi_pat  = sys_wdata;
        3'd2: cfg_d.miso_flag = sys_wdata[0];
        3'd3: cfg_d.miso_mask = sys_wdata;
        3'd4: cfg_d.miso_pat  = sys_wdata;
        3'd5: cfg_d.nbits     = sys_wdata[5:0];
        3'd6: en_d            = sys_wdata[0];
        default: begin
          trig_cnt_d  = '0;
          abort_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < SYNC_STG; i++) sync_q[i] <= '0;
      prev_q      <= '0;
      state_q     <= IDLE;
      cfg_q       <= '0;
      shd_q       <= '0;
      en_q        <= 1'b0;
      mosi_sr_q   <= '0;
      miso_sr_q   <= '0;
      bit_cnt_q   <= '0;
      trig_cnt_q  <= '0;
      abort_cnt_q <= '0;
      mpw_q       <= '0;
      tpw_q       <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      for (int i = 0; i < SYNC_STG; i++) sync_q[i] <= sync_d[i];
      prev_q      <= prev_d;
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      shd_q       <= shd_d;
      en_q        <= en_d;
      mosi_sr_q   <= mosi_sr_d;
      miso_sr_q   <= miso_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      trig_cnt_q  <= trig_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      mpw_q       <= mpw_d;
      tpw_q       <= tpw_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_spi_frame_trig.sv
// Bench for spi_frame_trig: directed frames plus randomized frames checked against a pattern-match model.
module tb_spi_frame_trig;
  logic        clk_i = 1'b0, rstn_i = 1'b0;
  logic        spi_cs_i = 1'b1, spi_sclk_i = 1'b0, spi_mosi_i = 1'b0, spi_miso_i = 1'b0;
  logic [31:0] sys_addr = '0, sys_wdata = '0;
  logic        sys_wen = 1'b0, sys_ren = 1'b0;
  logic [31:0] sys_rdata;
  logic        sys_ack, trg_o, mosi_trg_o, busy_o;

  int n_cmp = 0, n_fail = 0;
  int exp_trig = 0, exp_abort = 0;
  int mq[$], tq[$];
  int mrun = 0, trun = 0;

  always #5 clk_i = ~clk_i;

  spi_frame_trig #(.SYNC_STG(2), .TRG_LEN(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .spi_cs_i(spi_cs_i), .spi_sclk_i(spi_sclk_i), .spi_mosi_i(spi_mosi_i), .spi_miso_i(spi_miso_i),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack),
    .trg_o(trg_o), .mosi_trg_o(mosi_trg_o), .busy_o(busy_o)
  );

  // Record the width of every completed pulse on each trigger output.
  always @(negedge clk_i) begin
    if (mosi_trg_o) mrun++;
    else if (mrun != 0) begin mq.push_back(mrun); mrun = 0; end
    if (trg_o) trun++;
    else if (trun != 0) begin tq.push_back(trun); trun = 0; end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    tick(1);
    sys_wen = 1'b0;
    chk("wr_ack", {31'd0, sys_ack}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ack);
    sys_addr = a; sys_ren = 1'b1;
    tick(1);
    sys_ren = 1'b0;
    d = sys_rdata; ack = sys_ack;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d; logic ack;
    bus_read(a, d, ack);
    chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
    chk(tag, d, exp);
  endtask

  task automatic cfg(input logic [31:0] mmask, mpat, input logic flag,
                     input logic [31:0] smask, spat, input int nb, input logic en);
    bus_write(32'h60, mmask);
    bus_write(32'h64, mpat);
    bus_write(32'h68, {31'd0, flag});
    bus_write(32'h6C, smask);
    bus_write(32'h70, spat);
    bus_write(32'h74, 32'(nb));
    bus_write(32'h78, {31'd0, en});
  endtask

  task automatic send_bits(input logic [31:0] mw, sw, input int n, input int stop_after = 99,
                           input bit join_last = 0, input int mid_at = -1,
                           input logic [31:0] mid_addr = 0, input logic [31:0] mid_data = 0);
    for (int i = 0; i < n && i < stop_after; i++) begin
      spi_mosi_i = mw[n-1-i];
      spi_miso_i = sw[n-1-i];
      tick(4);
      if (i == mid_at) bus_write(mid_addr, mid_data);
      spi_sclk_i = 1'b1;
      if (join_last && i == n-1) spi_cs_i = 1'b1;
      tick(4);
      spi_sclk_i = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] mw, sw, input int n, input int stop_after = 99,
                       input bit join_last = 0, input int mid_at = -1,
                       input logic [31:0] mid_addr = 0, input logic [31:0] mid_data = 0);
    spi_cs_i = 1'b0;
    tick(4);
    send_bits(mw, sw, n, stop_after, join_last, mid_at, mid_addr, mid_data);
    tick(4);
    spi_cs_i = 1'b1;
    tick(4);
  endtask

  task automatic check_pulses(input string tag, input int exp_m, input int exp_t);
    tick(30);
    chk({tag, "_mosi_cnt"}, mq.size(), exp_m);
    if (exp_m == 1 && mq.size() == 1) chk({tag, "_mosi_width"}, mq[0], 8);
    chk({tag, "_trg_cnt"}, tq.size(), exp_t);
    if (exp_t == 1 && tq.size() == 1) chk({tag, "_trg_width"}, tq[0], 8);
    chk({tag, "_busy_idle"}, {31'd0, busy_o}, 32'd0);
    mq.delete(); tq.delete();
  endtask

  function automatic logic [31:0] status_exp();
    return {16'(exp_abort), 16'(exp_trig)};
  endfunction

  initial begin
    logic [31:0] d;
    logic        ack;

    tick(3);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_trg", {31'd0, trg_o}, 0);
    chk("rst_mosi_trg", {31'd0, mosi_trg_o}, 0);
    chk("rst_ack", {31'd0, sys_ack}, 0);
    chk("rst_rdata", sys_rdata, 0);
    rstn_i = 1'b1;
    tick(2);
    read_chk("rst_status", 32'h7C, 0);
    read_chk("rst_mask", 32'h60, 0);

    // T1 basic match
    cfg(32'hFF, 32'hA5, 1'b0, 32'h0, 32'h0, 8, 1'b1);
    frame(32'hA5, 32'h0, 8);
    exp_trig++;
    check_pulses("t1", 1, 1);
    read_chk("t1_status", 32'h7C, status_exp());
    read_chk("t1_pat_rb", 32'h64, 32'hA5);
    read_chk("t1_nbits_rb", 32'h74, 32'd8);

    // T2 mismatch, then masked-off LSB
    frame(32'hA4, 32'h0, 8);
    check_pulses("t2_miss", 0, 0);
    bus_write(32'h60, 32'hFE);
    frame(32'hA4, 32'h0, 8);
    exp_trig++;
    check_pulses("t2_mask", 1, 1);

    // T3 MISO qualification
    cfg(32'hFF, 32'hA5, 1'b1, 32'hFF, 32'h3C, 8, 1'b1);
    frame(32'hA5, 32'h3D, 8);
    check_pulses("t3_miso_miss", 1, 0);
    frame(32'hA5, 32'h3C, 8);
    exp_trig++;
    check_pulses("t3_miso_hit", 1, 1);

    // T4 abort after 5 bits
    bus_write(32'h68, 32'h0);
    frame(32'hA5, 32'h0, 8, 5);
    exp_abort++;
    check_pulses("t4_abort", 0, 0);
    read_chk("t4_status", 32'h7C, status_exp());

    // Final SCLK rise coincident with CS rise still completes the frame
    frame(32'hA5, 32'h0, 8, 99, 1);
    exp_trig++;
    check_pulses("join_last", 1, 1);

    // T5 mid-frame pattern write affects only the next frame
    frame(32'hA5, 32'h0, 8, 99, 0, 3, 32'h64, 32'h0);
    exp_trig++;
    check_pulses("t5_shadow_cur", 1, 1);
    frame(32'hA5, 32'h0, 8);
    check_pulses("t5_shadow_next", 0, 0);

    // Disabled: CS fall ignored
    cfg(32'hFF, 32'hA5, 1'b0, 32'h0, 32'h0, 8, 1'b0);
    spi_cs_i = 1'b0;
    tick(6);
    chk("dis_busy", {31'd0, busy_o}, 0);
    send_bits(32'hA5, 32'h0, 8);
    spi_cs_i = 1'b1;
    tick(4);
    check_pulses("dis", 0, 0);

    // Clearing enable mid-frame lets the current frame finish
    bus_write(32'h78, 32'h1);
    frame(32'hA5, 32'h0, 8, 99, 0, 2, 32'h78, 32'h0);
    exp_trig++;
    check_pulses("en_clr_cur", 1, 1);
    frame(32'hA5, 32'h0, 8);
    check_pulses("en_clr_next", 0, 0);

    // nbits=0 -> full 32-bit frame
    cfg(32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 0, 1'b1);
    frame(32'hDEAD_BEEF, 32'h0, 32);
    exp_trig++;
    check_pulses("t5_32bit", 1, 1);
    read_chk("pre_clr_status", 32'h7C, status_exp());
    bus_write(32'h7C, 32'h0);
    exp_trig = 0; exp_abort = 0;
    read_chk("clr_status", 32'h7C, 0);

    // Foreign address is not acknowledged
    bus_read(32'h0C, d, ack);
    chk("bad_addr_ack", {31'd0, ack}, 0);

    // T6 async reset mid-shift and mid-pulse
    cfg(32'hFF, 32'hA5, 1'b0, 32'h0, 32'h0, 8, 1'b1);
    spi_cs_i = 1'b0;
    tick(4);
    send_bits(32'hA5, 32'h0, 8, 4);
    chk("t6_busy_pre", {31'd0, busy_o}, 1);
    rstn_i = 1'b0;
    #1;
    chk("t6_busy_rst", {31'd0, busy_o}, 0);
    spi_cs_i = 1'b1;
    tick(3);
    rstn_i = 1'b1;
    tick(2);
    cfg(32'hFF, 32'hA5, 1'b0, 32'h0, 32'h0, 8, 1'b1);
    spi_cs_i = 1'b0;
    tick(4);
    send_bits(32'hA5, 32'h0, 8);
    for (int k = 0; k < 40; k++) begin
      if (trg_o) break;
      tick(1);
    end
    chk("t6_pulse_up", {31'd0, trg_o}, 1);
    rstn_i = 1'b0;
    #1;
    chk("t6_trg_rst", {31'd0, trg_o}, 0);
    chk("t6_mosi_trg_rst", {31'd0, mosi_trg_o}, 0);
    chk("t6_busy_rst2", {31'd0, busy_o}, 0);
    spi_cs_i = 1'b1;
    tick(3);
    rstn_i = 1'b1;
    tick(3);
    mq.delete(); tq.delete();
    exp_trig = 0; exp_abort = 0;
    read_chk("t6_status_rst", 32'h7C, 0);
    cfg(32'hFF, 32'hA5, 1'b0, 32'h0, 32'h0, 8, 1'b1);
    frame(32'hA5, 32'h0, 8);
    exp_trig++;
    check_pulses("t6_after", 1, 1);

    // Randomized frames against the pattern-match model
    for (int r = 0; r < 16; r++) begin
      logic [31:0] pat, mask, spat, smask, dm, ds, lm;
      int nb, n, stop, mh, sh, fire;
      logic flag;
      nb    = $urandom_range(0, 40);
      n     = (nb == 0 || nb > 32) ? 32 : nb;
      pat   = $urandom; mask = $urandom;
      spat  = $urandom; smask = $urandom;
      flag  = 1'($urandom_range(0, 1));
      dm    = ($urandom_range(0, 1) == 1) ? (pat ^ ($urandom & ~mask)) : $urandom;
      ds    = ($urandom_range(0, 1) == 1) ? (spat ^ ($urandom & ~smask)) : $urandom;
      lm    = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      mh    = (((dm ^ pat) & mask & lm) == 0) ? 1 : 0;
      sh    = (((ds ^ spat) & smask & lm) == 0) ? 1 : 0;
      fire  = (mh == 1 && (flag == 1'b0 || sh == 1)) ? 1 : 0;
      stop  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : 99;
      cfg(mask, pat, flag, smask, spat, nb, 1'b1);
      frame(dm, ds, n, stop);
      if (stop < n) begin
        exp_abort++;
        check_pulses("rnd_abort", 0, 0);
      end else begin
        exp_trig += fire;
        check_pulses("rnd", mh, fire);
      end
    end
    read_chk("final_status", 32'h7C, status_exp());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
